// File: rtl/fifo_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_bank_arbiter_if
// Brief    : Request/grant/status bundle between two masters and the bank arbiter.
// Revision : 1.0  initial release
// ============================================================================
interface fifo_bank_arbiter_if #(
    parameter int BANK_NUM = 4,
    parameter int DEPTH    = 32
);
    localparam int ID_W  = $clog2(BANK_NUM);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                      wr_en_M0;
    logic [ID_W-1:0]           wr_id_M0;
    logic                      rd_en_M0;
    logic [ID_W-1:0]           rd_id_M0;
    logic                      wr_en_M1;
    logic [ID_W-1:0]           wr_id_M1;
    logic                      rd_en_M1;
    logic [ID_W-1:0]           rd_id_M1;
    logic                      gnt_wr_M0;
    logic                      gnt_rd_M0;
    logic                      gnt_wr_M1;
    logic                      gnt_rd_M1;
    logic [BANK_NUM-1:0]       bank_wr_en;
    logic [BANK_NUM-1:0]       bank_wr_src;
    logic [BANK_NUM-1:0]       bank_rd_en;
    logic [BANK_NUM-1:0]       bank_rd_dst;
    logic                      valid_M0;
    logic                      valid_M1;
    logic [ID_W-1:0]           valid_id_M0;
    logic [ID_W-1:0]           valid_id_M1;
    logic [BANK_NUM*CNT_W-1:0] occ;
    logic [BANK_NUM-1:0]       full;
    logic [BANK_NUM-1:0]       empty;

    modport master (
        output wr_en_M0, wr_id_M0, rd_en_M0, rd_id_M0,
        output wr_en_M1, wr_id_M1, rd_en_M1, rd_id_M1,
        input  gnt_wr_M0, gnt_rd_M0, gnt_wr_M1, gnt_rd_M1,
        input  bank_wr_en, bank_wr_src, bank_rd_en, bank_rd_dst,
        input  valid_M0, valid_M1, valid_id_M0, valid_id_M1,
        input  occ, full, empty
    );

    modport slave (
        input  wr_en_M0, wr_id_M0, rd_en_M0, rd_id_M0,
        input  wr_en_M1, wr_id_M1, rd_en_M1, rd_id_M1,
        output gnt_wr_M0, gnt_rd_M0, gnt_wr_M1, gnt_rd_M1,
        output bank_wr_en, bank_wr_src, bank_rd_en, bank_rd_dst,
        output valid_M0, valid_M1, valid_id_M0, valid_id_M1,
        output occ, full, empty
    );
endinterface
`default_nettype wire

// File: rtl/fifo_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_bank_arbiter
// Brief    : Two-master, per-bank round-robin access control with occupancy tracking.
// Revision : 1.0  initial release
// ============================================================================
module fifo_bank_arbiter #(
    parameter int BANK_NUM = 4,
    parameter int DEPTH    = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fifo_bank_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(BANK_NUM);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]    r_occ [BANK_NUM];
    logic [BANK_NUM-1:0] r_wpri;
    logic [BANK_NUM-1:0] r_rpri;
    logic                r_valid_m0;
    logic                r_valid_m1;
    logic [ID_W-1:0]     r_valid_id_m0;
    logic [ID_W-1:0]     r_valid_id_m1;

    logic [BANK_NUM-1:0] w_full;
    logic [BANK_NUM-1:0] w_empty;
    logic [BANK_NUM-1:0] w_wq0;
    logic [BANK_NUM-1:0] w_wq1;
    logic [BANK_NUM-1:0] w_rq0;
    logic [BANK_NUM-1:0] w_rq1;
    logic [BANK_NUM-1:0] w_wg0;
    logic [BANK_NUM-1:0] w_wg1;
    logic [BANK_NUM-1:0] w_rg0;
    logic [BANK_NUM-1:0] w_rg1;
    logic [BANK_NUM-1:0] w_wr_en;
    logic [BANK_NUM-1:0] w_rd_en;
    logic                w_gnt_rd_m0;
    logic                w_gnt_rd_m1;

    // Eligible per-bank requests; reset masks everything so no strobe escapes.
    always_comb begin
        w_full  = '0;
        w_empty = '0;
        w_wq0   = '0;
        w_wq1   = '0;
        w_rq0   = '0;
        w_rq1   = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            w_full[b]  = (r_occ[b] == CNT_W'(DEPTH));
            w_empty[b] = (r_occ[b] == '0);
            w_wq0[b]   = !rst && bus.wr_en_M0 && (bus.wr_id_M0 == ID_W'(b)) && !w_full[b];
            w_wq1[b]   = !rst && bus.wr_en_M1 && (bus.wr_id_M1 == ID_W'(b)) && !w_full[b];
            w_rq0[b]   = !rst && bus.rd_en_M0 && (bus.rd_id_M0 == ID_W'(b)) && !w_empty[b];
            w_rq1[b]   = !rst && bus.rd_en_M1 && (bus.rd_id_M1 == ID_W'(b)) && !w_empty[b];
        end
    end

    // Priority bit only matters when both masters contend for the same bank.
    assign w_wg0 = w_wq0 & (~w_wq1 | ~r_wpri);
    assign w_wg1 = w_wq1 & (~w_wq0 |  r_wpri);
    assign w_rg0 = w_rq0 & (~w_rq1 | ~r_rpri);
    assign w_rg1 = w_rq1 & (~w_rq0 |  r_rpri);

    assign w_wr_en     = w_wg0 | w_wg1;
    assign w_rd_en     = w_rg0 | w_rg1;
    assign w_gnt_rd_m0 = |w_rg0;
    assign w_gnt_rd_m1 = |w_rg1;

    assign bus.gnt_wr_M0   = |w_wg0;
    assign bus.gnt_wr_M1   = |w_wg1;
    assign bus.gnt_rd_M0   = w_gnt_rd_m0;
    assign bus.gnt_rd_M1   = w_gnt_rd_m1;
    assign bus.bank_wr_en  = w_wr_en;
    assign bus.bank_wr_src = w_wg1;
    assign bus.bank_rd_en  = w_rd_en;
    assign bus.bank_rd_dst = w_rg1;
    assign bus.valid_M0    = r_valid_m0;
    assign bus.valid_M1    = r_valid_m1;
    assign bus.valid_id_M0 = r_valid_id_m0;
    assign bus.valid_id_M1 = r_valid_id_m1;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;

    generate
        for (genvar g = 0; g < BANK_NUM; g++) begin : g_occ
            assign bus.occ[g*CNT_W +: CNT_W] = r_occ[g];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < BANK_NUM; b++) begin
                r_occ[b] <= '0;
            end
            r_wpri        <= '0;
            r_rpri        <= '0;
            r_valid_m0    <= 1'b0;
            r_valid_m1    <= 1'b0;
            r_valid_id_m0 <= '0;
            r_valid_id_m1 <= '0;
        end else begin
            for (int b = 0; b < BANK_NUM; b++) begin
                case ({w_wr_en[b], w_rd_en[b]})
                    2'b10:   r_occ[b] <= r_occ[b] + CNT_W'(1);
                    2'b01:   r_occ[b] <= r_occ[b] - CNT_W'(1);
                    default: r_occ[b] <= r_occ[b];
                endcase
            end
            // After a contended grant, point priority at the loser.
            r_wpri     <= r_wpri ^ (w_wq0 & w_wq1);
            r_rpri     <= r_rpri ^ (w_rq0 & w_rq1);
            r_valid_m0 <= w_gnt_rd_m0;
            r_valid_m1 <= w_gnt_rd_m1;
            if (w_gnt_rd_m0) begin
                r_valid_id_m0 <= bus.rd_id_M0;
            end
            if (w_gnt_rd_m1) begin
                r_valid_id_m1 <= bus.rd_id_M1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fifo_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_bank_arbiter
// Brief    : Scoreboard bench with a queue-level bank model and random traffic.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_bank_arbiter;
    localparam int BANK_NUM = 4;
    localparam int DEPTH    = 32;
    localparam int CNT_W    = 6;

    typedef struct {
        logic [3:0]  gnt;     // {rd_M1, wr_M1, rd_M0, wr_M0}
        logic [3:0]  wen;
        logic [3:0]  wsrc;
        logic [3:0]  ren;
        logic [3:0]  rdst;
        logic [23:0] occ;
        logic [3:0]  full;
        logic [3:0]  empty;
    } comb_exp_t;

    typedef struct {
        bit v0;
        int id0;
        bit v1;
        int id1;
    } valid_exp_t;

    logic clk;
    logic rst;
    fifo_bank_arbiter_if #(.BANK_NUM(BANK_NUM), .DEPTH(DEPTH)) bus ();

    fifo_bank_arbiter #(.BANK_NUM(BANK_NUM), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    comb_exp_t  gq[$];
    valid_exp_t vq[$];

    // Model: each bank is just a count of stored entries plus who is owed the next tie.
    int m_occ[BANK_NUM];
    bit m_wpri[BANK_NUM];
    bit m_rpri[BANK_NUM];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r,
                        input bit we0, input int wi0, input bit re0, input int ri0,
                        input bit we1, input int wi1, input bit re1, input int ri1);
        comb_exp_t  ce;
        valid_exp_t ve;
        bit gw0, gw1, gr0, gr1;
        @(negedge clk);
        rst          = r;
        bus.wr_en_M0 = we0; bus.wr_id_M0 = 2'(wi0);
        bus.rd_en_M0 = re0; bus.rd_id_M0 = 2'(ri0);
        bus.wr_en_M1 = we1; bus.wr_id_M1 = 2'(wi1);
        bus.rd_en_M1 = re1; bus.rd_id_M1 = 2'(ri1);

        gw0 = !r && we0 && (m_occ[wi0] < DEPTH);
        gw1 = !r && we1 && (m_occ[wi1] < DEPTH);
        if (gw0 && gw1 && wi0 == wi1) begin
            if (m_wpri[wi0]) gw0 = 1'b0; else gw1 = 1'b0;
            m_wpri[wi0] = !m_wpri[wi0];
        end
        gr0 = !r && re0 && (m_occ[ri0] > 0);
        gr1 = !r && re1 && (m_occ[ri1] > 0);
        if (gr0 && gr1 && ri0 == ri1) begin
            if (m_rpri[ri0]) gr0 = 1'b0; else gr1 = 1'b0;
            m_rpri[ri0] = !m_rpri[ri0];
        end

        ce.gnt  = {gr1, gw1, gr0, gw0};
        ce.wen  = '0; ce.wsrc = '0; ce.ren = '0; ce.rdst = '0;
        if (gw0) ce.wen[wi0] = 1'b1;
        if (gw1) begin ce.wen[wi1] = 1'b1; ce.wsrc[wi1] = 1'b1; end
        if (gr0) ce.ren[ri0] = 1'b1;
        if (gr1) begin ce.ren[ri1] = 1'b1; ce.rdst[ri1] = 1'b1; end
        for (int b = 0; b < BANK_NUM; b++) begin
            ce.occ[b*CNT_W +: CNT_W] = 6'(m_occ[b]);
            ce.full[b]  = (m_occ[b] == DEPTH);
            ce.empty[b] = (m_occ[b] == 0);
        end
        gq.push_back(ce);
        ve.v0 = gr0; ve.id0 = ri0; ve.v1 = gr1; ve.id1 = ri1;
        vq.push_back(ve);

        if (r) begin
            for (int b = 0; b < BANK_NUM; b++) begin
                m_occ[b] = 0; m_wpri[b] = 1'b0; m_rpri[b] = 1'b0;
            end
        end else begin
            if (gw0) m_occ[wi0]++;
            if (gw1) m_occ[wi1]++;
            if (gr0) m_occ[ri0]--;
            if (gr1) m_occ[ri1]--;
        end
    endtask

    task automatic idle(input bit r);
        step(r, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Combinational monitor: grants, strobes and status in the middle of each cycle.
    initial begin
        comb_exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (gq.size() > 0) begin
                e = gq.pop_front();
                chk("grants", {28'd0, bus.gnt_rd_M1, bus.gnt_wr_M1, bus.gnt_rd_M0, bus.gnt_wr_M0}, {28'd0, e.gnt});
                chk("bank_wr_en",  {28'd0, bus.bank_wr_en},  {28'd0, e.wen});
                chk("bank_wr_src", {28'd0, bus.bank_wr_src}, {28'd0, e.wsrc});
                chk("bank_rd_en",  {28'd0, bus.bank_rd_en},  {28'd0, e.ren});
                chk("bank_rd_dst", {28'd0, bus.bank_rd_dst}, {28'd0, e.rdst});
                chk("occ",   {8'd0, bus.occ},     {8'd0, e.occ});
                chk("full",  {28'd0, bus.full},   {28'd0, e.full});
                chk("empty", {28'd0, bus.empty},  {28'd0, e.empty});
            end
        end
    end

    // Registered read-valid monitor, one expectation per issued cycle.
    initial begin
        valid_exp_t v;
        forever begin
            @(posedge clk);
            #1;
            if (vq.size() > 0) begin
                v = vq.pop_front();
                chk("valid_M0", {31'd0, bus.valid_M0}, {31'd0, v.v0});
                chk("valid_M1", {31'd0, bus.valid_M1}, {31'd0, v.v1});
                if (v.v0) chk("valid_id_M0", {30'd0, bus.valid_id_M0}, 32'(v.id0));
                if (v.v1) chk("valid_id_M1", {30'd0, bus.valid_id_M1}, 32'(v.id1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        bus.wr_en_M0 = 1'b0; bus.wr_id_M0 = '0; bus.rd_en_M0 = 1'b0; bus.rd_id_M0 = '0;
        bus.wr_en_M1 = 1'b0; bus.wr_id_M1 = '0; bus.rd_en_M1 = 1'b0; bus.rd_id_M1 = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            m_occ[b] = 0; m_wpri[b] = 1'b0; m_rpri[b] = 1'b0;
        end

        // Reset, then idle.
        idle(1);
        repeat (5) idle(0);
        #2;
        chk("reset_empty", {28'd0, bus.empty}, 32'hF);
        chk("reset_valid", {31'd0, bus.valid_M0 | bus.valid_M1}, 32'd0);

        // Fill bank 2 to DEPTH and one extra.
        repeat (DEPTH + 1) step(0, 1, 2, 0, 0, 0, 0, 0, 0);
        idle(0);
        #2;
        chk("bank2_full_occ", {26'd0, bus.occ[2*CNT_W +: CNT_W]}, 32'd32);
        chk("bank2_full_flag", {31'd0, bus.full[2]}, 32'd1);

        // Contended writes to bank 1 alternate M0, M1.
        idle(1);
        repeat (4) step(0, 1, 1, 0, 0, 1, 1, 0, 0);
        idle(0);
        #2;
        chk("bank1_occ", {26'd0, bus.occ[1*CNT_W +: CNT_W]}, 32'd4);

        // Single entry in bank 3, both read, then M1 retries.
        idle(1);
        step(0, 1, 3, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 3, 0, 0, 1, 3);
        step(0, 0, 0, 0, 0, 0, 0, 1, 3);
        idle(0);
        #2;
        chk("bank3_empty", {31'd0, bus.empty[3]}, 32'd1);

        // Concurrent write and read to bank 0 holding 5 entries.
        idle(1);
        repeat (5) step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 1, 0);
        idle(0);
        #2;
        chk("bank0_occ", {26'd0, bus.occ[0*CNT_W +: CNT_W]}, 32'd5);

        // Read granted, then reset drops the valid and clears state.
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(1);
        idle(0);
        #2;
        chk("rst_drops_valid", {31'd0, bus.valid_M0}, 32'd0);
        chk("rst_occ_zero", {8'd0, bus.occ}, 32'd0);

        // Random traffic, write-biased so banks reach full, with rare resets.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1), int'($urandom_range(0, 3)));
        end
        idle(0);
        idle(0);
        @(negedge clk);
        #3;
        chk("scoreboard_drained", 32'(gq.size() + vq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fifo_bank_arbiter.md
Name: fifo_bank_arbiter

Overview:
- Access controller in front of the four-bank FIFO storage, shared by two masters (M0, M1).
- Each master can issue one write and one read per cycle. Each request targets an explicit bank.
- The block resolves same-bank conflicts with per-bank round-robin and tracks per-bank occupancy.
- It blocks writes to full banks and reads from empty banks, and drives the bank strobes plus the registered read-valid flags.

Parameters:
- BANK_NUM, 4, number of banks.
- DEPTH, 32, entries per bank.
- ID_W, $clog2(BANK_NUM), bank-id width (derived; do not override).
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived; 6 at default).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; one clock, synchronous active-high.
- wr_en_M0  in  1  M0 write request.
- wr_id_M0  in  ID_W  M0 write target bank.
- rd_en_M0  in  1  M0 read request.
- rd_id_M0  in  ID_W  M0 read target bank.
- wr_en_M1, wr_id_M1, rd_en_M1, rd_id_M1  in  1/ID_W/1/ID_W  same as M0, for M1.
- gnt_wr_M0, gnt_rd_M0, gnt_wr_M1, gnt_rd_M1  out  1 each  combinational grants.
- bank_wr_en  out  BANK_NUM  write strobe per bank.
- bank_wr_src  out  BANK_NUM  per bank: 0 = data from M0, 1 = data from M1.
- bank_rd_en  out  BANK_NUM  read strobe per bank.
- bank_rd_dst  out  BANK_NUM  per bank: 0 = data to M0, 1 = data to M1.
- valid_M0, valid_M1  out  1 each  registered; read data for that master is on the storage output this cycle.
- valid_id_M0, valid_id_M1  out  ID_W each  registered; bank that supplied the data.
- occ  out  BANK_NUM*CNT_W  per-bank occupancy; bank b at [b*CNT_W +: CNT_W].
- full, empty  out  BANK_NUM each  full[b] = (occ_b == DEPTH); empty[b] = (occ_b == 0).

Behaviour:
- Reset (rst high at posedge):
  - occ = 0 all banks; empty = all 1; full = all 0.
  - Write priority bits wpri[b] = 0 and read priority bits rpri[b] = 0 (M0 favoured).
  - valid_M0/M1 = 0; valid_id = 0.
  - While rst is high, all grants and bank strobes are forced 0. This applies mid-operation too: an in-flight read valid is dropped the cycle after reset.
- Write eligibility: a request is eligible only if full[target] = 0. No same-cycle read-frees-slot bypass.
- Read eligibility: a request is eligible only if empty[target] = 0. No write-through.
- Write arbitration per bank b, independent of other banks:
  - One eligible requester targets b: it is granted.
  - Both target b: the master selected by wpri[b] (0 = M0, 1 = M1) is granted. The loser gets no grant and must hold its request.
  - On a contended grant, wpri[b] is set to point at the loser. Uncontended grants leave wpri unchanged.
- Read arbitration per bank: identical to writes, using rpri[b].
- Read and write independence:
  - A write and a read to the same bank in the same cycle are both granted when each is eligible.
  - A master may be granted a write and a read in the same cycle.
- Strobes:
  - bank_wr_en[b] = any write granted to b; bank_wr_src[b] = granted master. bank_wr_src = 0 when idle.
  - bank_rd_en and bank_rd_dst follow the same rule for reads.
- Occupancy update at posedge: occ_b += 1 on a granted write; -= 1 on a granted read; unchanged when both occur. It never wraps, since eligibility prevents overflow and underflow.
- Read latency: gnt_rd_Mx at cycle t gives valid_Mx = 1 and valid_id_Mx = bank at t+1, for exactly one cycle per grant.
- Out-of-range ids cannot occur (ID_W exact for BANK_NUM a power of two); BANK_NUM must be a power of two.

Test Plan:
- Reset then idle, 5 cycles → occ all 0, empty = 4'b1111, full = 0, all grants, strobes and valids 0.
- M0 writes bank 2 for 32 consecutive cycles, then a 33rd write → the first 32 are granted and occ_2 reaches 32 with full[2] = 1; the 33rd gets gnt_wr_M0 = 0 and occ_2 stays 32.
- Both masters write bank 1 continuously for 4 cycles from reset → grants go M0, M1, M0, M1; bank_wr_src[1] = 0,1,0,1; occ_1 = 4.
- Bank 3 holds 1 entry; M0 and M1 both read bank 3 → only M0 is granted; next cycle valid_M0 = 1 with valid_id_M0 = 3, valid_M1 = 0. M1 retries → denied (empty[3] = 1).
- Bank 0 holds 5 entries; same cycle M0 writes bank 0 and M1 reads bank 0 → both granted, occ_0 stays 5; next cycle valid_M1 = 1 with valid_id_M1 = 0.
- Grant a read at cycle t with rst asserted at posedge t+1 → valid_M0 = 0 at t+1 onward, occ all 0, priority bits 0.
